// File: rtl/mem_arbiter.sv
// Serialises a group memory operation from N_CORES cores onto one memory port,
// lowest-index core first, with read capture pipelined behind each issue.
module mem_arbiter #(
    parameter int N_CORES = 8,
    parameter int AW      = 16,
    parameter int DW      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MRead,
    input  logic                  MWrite,
    output logic                  MReady,
    input  logic [N_CORES-1:0]    en,
    input  logic [N_CORES*AW-1:0] addr,
    input  logic [N_CORES*DW-1:0] data,
    output logic [N_CORES*DW-1:0] q,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DW-1:0]         mem_rdata
);

    localparam int IW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                state_q, state_d;
    logic [N_CORES-1:0]    pend_q, pend_d;
    logic                  wr_q, wr_d;
    logic                  rd_vld_q, rd_vld_d;
    logic [IW-1:0]         rd_idx_q, rd_idx_d;
    logic [IW-1:0]         sel;
    logic                  found;
    logic [N_CORES*DW-1:0] q_q;

    // Lowest-index pending core.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N_CORES; i++) begin
            if (!found && pend_q[i]) begin
                sel   = IW'(i);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        wr_d      = wr_q;
        rd_vld_d  = 1'b0;
        rd_idx_d  = rd_idx_q;
        MReady    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        case (state_q)
            IDLE: begin
                if (MRead || MWrite) begin
                    pend_d  = en;
                    wr_d    = MWrite;
                    state_d = (|en) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                mem_addr = addr[sel*AW +: AW];
                if (wr_q) begin
                    mem_wdata = data[sel*DW +: DW];
                    mem_we    = 1'b1;
                end else begin
                    mem_re   = 1'b1;
                    rd_vld_d = 1'b1;
                    rd_idx_d = sel;
                end
                // Clearing the lowest set bit retires exactly the selected core.
                pend_d = pend_q & (pend_q - 1'b1);
                if (pend_d == '0) begin
                    state_d = wr_q ? DONE : WAIT;
                end
            end
            WAIT:    state_d = DONE;
            DONE: begin
                MReady  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pend_q   <= '0;
            wr_q     <= 1'b0;
            rd_vld_q <= 1'b0;
            rd_idx_q <= '0;
            q_q      <= '0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            wr_q     <= wr_d;
            rd_vld_q <= rd_vld_d;
            rd_idx_q <= rd_idx_d;
            if (rd_vld_q) begin
                q_q[rd_idx_q*DW +: DW] <= mem_rdata;
            end
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a one-cycle-latency memory model.
module tb_mem_arbiter;

    localparam int N  = 8;
    localparam int AW = 16;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              MRead = 1'b0;
    logic              MWrite = 1'b0;
    logic              MReady;
    logic [N-1:0]      en = '0;
    logic [N*AW-1:0]   addr = '0;
    logic [N*DW-1:0]   data = '0;
    logic [N*DW-1:0]   q;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DW-1:0]     mem_rdata = '0;

    mem_arbiter #(.N_CORES(N), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .MRead(MRead), .MWrite(MWrite), .MReady(MReady),
        .en(en), .addr(addr), .data(data), .q(q),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: read data appears the cycle after mem_re.
    logic [DW-1:0] mem [0:65535];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0] rd_addr_log[$];
    int            rd_cyc_log[$];
    logic [AW-1:0] wr_addr_log[$];
    logic [DW-1:0] wr_data_log[$];
    int            ready_cnt = 0;
    int            ready_cyc = 0;
    bit            both_seen = 0;
    bit            idle_drive = 0;
    always @(negedge clk) begin
        if (mem_re) begin
            rd_addr_log.push_back(mem_addr);
            rd_cyc_log.push_back(cyc);
        end
        if (mem_we) begin
            wr_addr_log.push_back(mem_addr);
            wr_data_log.push_back(mem_wdata);
        end
        if (MReady) begin
            ready_cnt = ready_cnt + 1;
            ready_cyc = cyc;
        end
        if (mem_we && mem_re) both_seen = 1;
        if (!mem_we && !mem_re && (mem_addr != '0 || mem_wdata != '0)) idle_drive = 1;
    end

    int checks = 0;
    int passes = 0;
    int t0, rd_base, wr_base, rdy_base, lat;

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic start_op(input logic rd, input logic wr, input logic [N-1:0] m);
        rd_base  = rd_addr_log.size();
        wr_base  = wr_addr_log.size();
        rdy_base = ready_cnt;
        en = m; MRead = rd; MWrite = wr;
        @(posedge clk); #1;
        t0 = cyc;
        MRead = 1'b0; MWrite = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (ready_cnt == rdy_base && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ready_cnt == rdy_base) $display("FAIL %s_timeout: got no MReady, required one within 40 cycles", name);
        else passes++;
        lat = ready_cyc - t0 + 1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (MReady !== 1'b0) $display("FAIL rst_mready: got %b required 0", MReady); else passes++;
        checks++; if ({mem_we, mem_re} !== 2'b00) $display("FAIL rst_strobes: got %b required 00", {mem_we, mem_re}); else passes++;
        checks++; if ({mem_addr, mem_wdata} !== '0) $display("FAIL rst_bus: got %h required 0", {mem_addr, mem_wdata}); else passes++;
        checks++; if (q !== '0) $display("FAIL rst_q: got %h required 0", q); else passes++;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_read_all();
        for (int i = 0; i < N; i++) begin
            preload(AW'(i + 16), DW'(100 + i));
            addr[i*AW +: AW] = AW'(i + 16);
        end
        start_op(1'b1, 1'b0, 8'hFF);
        wait_ready("read_all");
        checks++; if (rd_addr_log.size() - rd_base != 8) $display("FAIL read_all_count: got %0d required 8", rd_addr_log.size() - rd_base); else passes++;
        checks++; if (wr_addr_log.size() != wr_base) $display("FAIL read_all_nowrite: got %0d writes required 0", wr_addr_log.size() - wr_base); else passes++;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (rd_addr_log[rd_base + i] !== AW'(i + 16) || rd_cyc_log[rd_base + i] != t0 + i)
                $display("FAIL read_all_issue%0d: got addr %0d cyc %0d required addr %0d cyc %0d",
                         i, rd_addr_log[rd_base + i], rd_cyc_log[rd_base + i], i + 16, t0 + i);
            else passes++;
            checks++;
            if (q[i*DW +: DW] !== DW'(100 + i)) $display("FAIL read_all_q%0d: got %0d required %0d", i, q[i*DW +: DW], 100 + i);
            else passes++;
        end
        checks++; if (lat != 10) $display("FAIL read_all_latency: got %0d required 10", lat); else passes++;
        checks++; if (ready_cnt - rdy_base != 1) $display("FAIL read_all_ready_count: got %0d required 1", ready_cnt - rdy_base); else passes++;
    endtask

    task automatic test_sparse_write();
        for (int i = 0; i < N; i++) begin
            addr[i*AW +: AW] = AW'(200 + i);
            data[i*DW +: DW] = DW'(i * 3);
        end
        start_op(1'b0, 1'b1, 8'b1010_0100);
        wait_ready("sparse_wr");
        checks++; if (wr_addr_log.size() - wr_base != 3) $display("FAIL sparse_wr_count: got %0d required 3", wr_addr_log.size() - wr_base); else passes++;
        checks++; if (rd_addr_log.size() != rd_base) $display("FAIL sparse_wr_noread: got %0d reads required 0", rd_addr_log.size() - rd_base); else passes++;
        checks++;
        if (wr_addr_log[wr_base] !== 16'd202 || wr_data_log[wr_base] !== 16'd6 ||
            wr_addr_log[wr_base+1] !== 16'd205 || wr_data_log[wr_base+1] !== 16'd15 ||
            wr_addr_log[wr_base+2] !== 16'd207 || wr_data_log[wr_base+2] !== 16'd21)
            $display("FAIL sparse_wr_order: got (%0d,%0d)(%0d,%0d)(%0d,%0d) required (202,6)(205,15)(207,21)",
                     wr_addr_log[wr_base], wr_data_log[wr_base], wr_addr_log[wr_base+1], wr_data_log[wr_base+1],
                     wr_addr_log[wr_base+2], wr_data_log[wr_base+2]);
        else passes++;
        checks++; if (mem[207] !== 16'd21) $display("FAIL sparse_wr_mem: got %0d required 21", mem[207]); else passes++;
        checks++; if (lat != 4) $display("FAIL sparse_wr_latency: got %0d required 4", lat); else passes++;
        checks++; if (q[2*DW +: DW] !== 16'd102) $display("FAIL sparse_wr_q_hold: got %0d required 102", q[2*DW +: DW]); else passes++;
    endtask

    task automatic test_both_requests();
        addr[0 +: AW] = 16'd300;
        data[0 +: DW] = 16'hBEEF;
        start_op(1'b1, 1'b1, 8'h01);
        wait_ready("both");
        checks++; if (wr_addr_log.size() - wr_base != 1 || rd_addr_log.size() != rd_base)
            $display("FAIL both_kind: got %0d writes %0d reads required 1 write 0 reads", wr_addr_log.size() - wr_base, rd_addr_log.size() - rd_base);
        else passes++;
        checks++; if (mem[300] !== 16'hBEEF) $display("FAIL both_mem: got %h required beef", mem[300]); else passes++;
        checks++; if (q[0 +: DW] !== 16'd100) $display("FAIL both_q0: got %0d required 100", q[0 +: DW]); else passes++;
        checks++; if (lat != 2) $display("FAIL both_latency: got %0d required 2", lat); else passes++;
    endtask

    task automatic test_empty_mask();
        start_op(1'b1, 1'b0, 8'h00);
        wait_ready("empty");
        checks++; if (rd_addr_log.size() != rd_base || wr_addr_log.size() != wr_base)
            $display("FAIL empty_strobes: got %0d reads %0d writes required 0", rd_addr_log.size() - rd_base, wr_addr_log.size() - wr_base);
        else passes++;
        checks++; if (lat != 1) $display("FAIL empty_latency: got %0d required 1", lat); else passes++;
    endtask

    task automatic test_busy_request();
        for (int i = 0; i < N; i++) begin
            preload(AW'(i + 16), DW'(500 + i));
            addr[i*AW +: AW] = AW'(i + 16);
        end
        start_op(1'b1, 1'b0, 8'hFF);
        en = 8'h00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        MWrite = 1'b1;
        @(posedge clk); #1;
        MWrite = 1'b0;
        wait_ready("busy");
        checks++; if (rd_addr_log.size() - rd_base != 8 || wr_addr_log.size() != wr_base)
            $display("FAIL busy_accesses: got %0d reads %0d writes required 8 reads 0 writes", rd_addr_log.size() - rd_base, wr_addr_log.size() - wr_base);
        else passes++;
        checks++; if (ready_cnt - rdy_base != 1) $display("FAIL busy_ready_count: got %0d required 1", ready_cnt - rdy_base); else passes++;
        checks++; if (q[7*DW +: DW] !== 16'd507 || q[0 +: DW] !== 16'd500)
            $display("FAIL busy_q: got q7=%0d q0=%0d required 507 500", q[7*DW +: DW], q[0 +: DW]);
        else passes++;
        checks++; if (lat != 10) $display("FAIL busy_latency: got %0d required 10", lat); else passes++;
    endtask

    task automatic test_back_to_back();
        int seen = 0;
        int n = 0;
        rd_base = rd_addr_log.size(); wr_base = wr_addr_log.size(); rdy_base = ready_cnt;
        data[0 +: DW] = 16'h1234;
        en = 8'h01; MWrite = 1'b1;
        while (seen < 2 && n < 40) begin
            @(negedge clk);
            n++;
            if (MReady) seen++;
        end
        MWrite = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (seen != 2) $display("FAIL b2b_timeout: got %0d MReady within 40 cycles required 2", seen); else passes++;
        checks++; if (wr_addr_log.size() - wr_base != 2 || ready_cnt - rdy_base != 2)
            $display("FAIL b2b_ops: got %0d writes %0d MReady required 2 and 2", wr_addr_log.size() - wr_base, ready_cnt - rdy_base);
        else passes++;
    endtask

    task automatic test_reset_mid_read();
        start_op(1'b1, 1'b0, 8'hFF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if ({mem_we, mem_re, MReady} !== 3'b000) $display("FAIL rstmid_strobes: got %b required 000", {mem_we, mem_re, MReady}); else passes++;
        checks++; if (mem_addr !== '0) $display("FAIL rstmid_addr: got %0d required 0", mem_addr); else passes++;
        checks++; if (q !== '0) $display("FAIL rstmid_q: got %h required 0", q); else passes++;
        repeat (15) @(posedge clk);
        #1;
        checks++; if (q !== '0) $display("FAIL rstmid_q_late: got %h required 0", q); else passes++;
        checks++; if (ready_cnt != rdy_base) $display("FAIL rstmid_no_ready: got %0d MReady required 0", ready_cnt - rdy_base); else passes++;
        checks++; if (rd_addr_log.size() - rd_base != 3) $display("FAIL rstmid_reads: got %0d required 3", rd_addr_log.size() - rd_base); else passes++;
    endtask

    initial begin
        test_reset();
        test_read_all();
        test_sparse_write();
        test_both_requests();
        test_empty_mask();
        test_busy_request();
        test_back_to_back();
        test_reset_mid_read();
        checks++; if (both_seen) $display("FAIL strobe_exclusive: got both strobes high required never"); else passes++;
        checks++; if (idle_drive) $display("FAIL bus_idle_zero: got nonzero addr/wdata without strobe required 0"); else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter N_CORES, default 8, giving the number of SP cores sharing one memory port.
REQ-002 The block SHALL have parameter AW, default 16, giving the address width.
REQ-003 The block SHALL have parameter DW, default 16, giving the data width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port MRead, input, 1 bit: level request for a read by all enabled cores.
REQ-007 The block SHALL have port MWrite, input, 1 bit: level request for a write by all enabled cores.
REQ-008 The block SHALL have port MReady, output, 1 bit: one-cycle done pulse for the whole group operation.
REQ-009 The block SHALL have port en, input, N_CORES bits: per-core participation mask.
REQ-010 The block SHALL have port addr, input, N_CORES*AW bits: per-core address; core i occupies bits [i*AW +: AW].
REQ-011 The block SHALL have port data, input, N_CORES*DW bits: per-core write data, same packing as addr.
REQ-012 The block SHALL have port q, output, N_CORES*DW bits: per-core registered read data, same packing as addr.
REQ-013 The block SHALL have port mem_addr, output, AW bits: shared memory address.
REQ-014 The block SHALL have port mem_wdata, output, DW bits: shared memory write data.
REQ-015 The block SHALL have port mem_we, output, 1 bit: memory write strobe.
REQ-016 The block SHALL have port mem_re, output, 1 bit: memory read strobe.
REQ-017 The block SHALL have port mem_rdata, input, DW bits: memory read data, valid the cycle after mem_re.

Function
REQ-018 The FSM SHALL have four states: IDLE, ISSUE, WAIT and DONE.
REQ-019 In IDLE, with MRead or MWrite high at an edge, the block SHALL latch en into a pending mask and latch the operation; MWrite wins if both are high.
REQ-020 The IDLE transition SHALL go to ISSUE if the latched mask is nonzero, else directly to DONE.
REQ-021 In each ISSUE cycle, the block SHALL select the lowest-index pending core i and drive mem_addr=addr[i]; for a write it SHALL also drive mem_wdata=data[i] and mem_we=1; for a read it SHALL drive mem_re=1.
REQ-022 In each ISSUE cycle, the block SHALL clear pending bit i at the end of the cycle.
REQ-023 Exactly one memory access SHALL be issued per ISSUE cycle; no bubbles between accesses.
REQ-024 The block SHALL register the index of each issued read and write mem_rdata into q[i] at the end of the following cycle.
REQ-025 For every core that is not enabled, q SHALL be left unchanged.
REQ-026 Read pipelining: the capture for access n SHALL overlap the issue of access n+1.
REQ-027 After the last issue, the FSM SHALL go to WAIT for a read (final capture) and to DONE for a write.
REQ-028 WAIT SHALL last one cycle and then go to DONE.
REQ-029 In DONE, MReady SHALL be 1 for exactly one cycle, and the FSM SHALL then go to IDLE.
REQ-030 Latency: with a request sampled at edge t0 and k enabled cores, MReady SHALL be high in cycle t0+k+2 for a read, t0+k+1 for a write, and t0+1 for k=0.
REQ-031 mem_we, mem_re, mem_addr and mem_wdata SHALL be 0 outside ISSUE.
REQ-032 mem_we and mem_re SHALL never both be 1.
REQ-033 MRead and MWrite SHALL be ignored outside IDLE.
REQ-034 Changes to en after acceptance SHALL have no effect on the operation in progress.
REQ-035 The requester SHALL hold addr and data stable until MReady; the block samples them live in ISSUE.
REQ-036 Requests are level-sensitive: if MRead or MWrite is still high in IDLE after DONE, a new operation SHALL start.
REQ-037 The controller SHALL drop MRead and MWrite in the MReady cycle.

Reset
REQ-038 When reset is high at an edge, the block SHALL go to IDLE and clear the pending mask, regardless of state, including in the middle of an operation.
REQ-039 When reset is high at an edge, MReady, mem_we, mem_re, mem_addr, mem_wdata and all q SHALL be 0.
REQ-040 A read capture that is in flight when reset is applied SHALL be discarded.
REQ-041 Reset SHALL take priority over a simultaneous MRead or MWrite.

Verification
REQ-042 Read, all enabled: N_CORES=8, en=8'hFF, addr[i]=i+16, memory holds word 100+i at address i+16, MRead pulse -> mem_re for 8 consecutive cycles with addresses 16..23, q[i]=100+i, and MReady exactly 10 cycles after acceptance.
REQ-043 Sparse write: en=8'b1010_0100, data[i]=i*3, MWrite -> writes in order core 2 (value 6), core 5 (value 15), core 7 (value 21), and MReady at cycle 4.
REQ-044 Empty mask: en=0 with MRead -> no mem_re or mem_we, and MReady at cycle 1.
REQ-045 Both requests: MRead=MWrite=1 with en=8'h01 -> a write is performed and q[0] is unchanged.
REQ-046 Reset mid-read: reset asserted in the 3rd ISSUE cycle -> the next cycle is IDLE, strobes are 0, all q are 0, and no MReady occurs.
REQ-047 Request while busy: MWrite pulsed during a read ISSUE -> it is ignored, and only the read's accesses and a single MReady occur.
